// File: rtl/m4_pkg.sv
// Shared M4 channel constants and the sequencer state encoding.
package m4_pkg;

  localparam int unsigned M4_WORD_BITS   = 12;
  localparam int unsigned M4_FRAME_WORDS = 512;
  localparam int unsigned M4_GROUPS      = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    SHIFT = 2'd2
  } m4_state_e;

endpackage

// File: rtl/m4_bit_timer.sv
// Bit/word timing for the M4 serialiser: divider, bit counter, bit clock and
// decode of the fetch point and load point inside the last bit of a word.
module m4_bit_timer #(
  parameter int unsigned BIT_DIV   = 4,
  parameter int unsigned WORD_BITS = 12
) (
  input  logic clk,
  input  logic rst_n,
  input  logic shift_now_i,
  input  logic shift_next_i,
  output logic ser_clk_o,
  output logic fetch_pt_c,
  output logic bit_end_c,
  output logic load_pt_c
);

  localparam int unsigned DIV_W = $clog2(BIT_DIV);
  localparam int unsigned BIT_W = $clog2(WORD_BITS);

  logic [DIV_W-1:0] div_q, div_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic             ser_clk_q, ser_clk_d;
  logic             last_bit;

  assign last_bit   = (bit_q == BIT_W'(WORD_BITS - 1));
  assign bit_end_c  = shift_now_i && (div_q == DIV_W'(BIT_DIV - 1));
  assign fetch_pt_c = shift_now_i && last_bit && (div_q == DIV_W'(BIT_DIV - 3));
  assign load_pt_c  = bit_end_c && last_bit;
  assign ser_clk_o  = ser_clk_q;

  // Counters only run while staying in SHIFT; entering or leaving SHIFT restarts them.
  always_comb begin
    div_d = '0;
    bit_d = '0;
    if (shift_now_i && shift_next_i) begin
      if (div_q == DIV_W'(BIT_DIV - 1)) begin
        div_d = '0;
        bit_d = last_bit ? '0 : bit_q + BIT_W'(1);
      end else begin
        div_d = div_q + DIV_W'(1);
        bit_d = bit_q;
      end
    end
    ser_clk_d = shift_next_i && (div_d < DIV_W'(BIT_DIV / 2));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q     <= '0;
      bit_q     <= '0;
      ser_clk_q <= 1'b0;
    end else begin
      div_q     <= div_d;
      bit_q     <= bit_d;
      ser_clk_q <= ser_clk_d;
    end
  end

endmodule

// File: rtl/m4_frame_sequencer.sv
// M4 channel timing master: issues word fetches, tracks frame pointer and group
// counter, and serialises returned words MSB-first with bit clock and sync pulses.
module m4_frame_sequencer
  import m4_pkg::*;
#(
  parameter int unsigned  BIT_DIV     = 4,
  parameter int unsigned  WORD_BITS   = M4_WORD_BITS,
  parameter int unsigned  FRAME_WORDS = M4_FRAME_WORDS,
  parameter int unsigned  GROUPS      = M4_GROUPS,
  localparam int unsigned PTR_W       = $clog2(FRAME_WORDS),
  localparam int unsigned GRP_W       = $clog2(GROUPS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic [WORD_BITS-1:0] dataWord,
  output logic                 bufGetWord,
  output logic [PTR_W-1:0]     bufRdPointer,
  output logic [GRP_W-1:0]     cntGrp,
  output logic                 serData,
  output logic                 serClk,
  output logic                 wordSync,
  output logic                 frameSync
);

  m4_state_e            state_q, state_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [GRP_W-1:0]     grp_q, grp_d;
  logic [WORD_BITS-1:0] shift_q, shift_d;
  logic                 prime_q, prime_d;
  logic                 stop_q, stop_d;
  logic                 frame_pend_q, frame_pend_d;
  logic                 get_q, get_d;
  logic                 ser_data_q, ser_data_d;
  logic                 word_sync_q, word_sync_d;
  logic                 frame_sync_q, frame_sync_d;
  logic                 fetch, load;
  logic                 fetch_pt_c, bit_end_c, load_pt_c;

  m4_bit_timer #(
    .BIT_DIV   (BIT_DIV),
    .WORD_BITS (WORD_BITS)
  ) u_bit_timer (
    .clk          (clk),
    .rst_n        (reset),
    .shift_now_i  (state_q == SHIFT),
    .shift_next_i (state_d == SHIFT),
    .ser_clk_o    (serClk),
    .fetch_pt_c   (fetch_pt_c),
    .bit_end_c    (bit_end_c),
    .load_pt_c    (load_pt_c)
  );

  // Next-state, fetch/load decisions and registered output values.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    grp_d        = grp_q;
    shift_d      = shift_q;
    prime_d      = 1'b0;
    stop_d       = stop_q;
    frame_pend_d = frame_pend_q;
    get_d        = 1'b0;
    word_sync_d  = 1'b0;
    frame_sync_d = 1'b0;
    fetch        = 1'b0;
    load         = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (en) begin
          fetch   = 1'b1;
          state_d = PRIME;
        end
      end
      PRIME: begin
        if (prime_q) begin
          load    = 1'b1;
          state_d = SHIFT;
        end else begin
          prime_d = 1'b1;
        end
      end
      SHIFT: begin
        if (fetch_pt_c) begin
          if (en) fetch = 1'b1;
          stop_d = !en;
        end
        if (bit_end_c) shift_d = shift_q << 1;
        if (load_pt_c) begin
          if (stop_q) begin
            state_d = IDLE;
            shift_d = '0;
            stop_d  = 1'b0;
          end else begin
            load = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Pointer and group advance together so the group change lands with pointer 0.
    if (fetch) begin
      get_d        = 1'b1;
      frame_pend_d = (ptr_q == PTR_W'(FRAME_WORDS - 1));
      if (ptr_q == PTR_W'(FRAME_WORDS - 1)) begin
        ptr_d = '0;
        grp_d = (grp_q == GRP_W'(GROUPS - 1)) ? '0 : grp_q + GRP_W'(1);
      end else begin
        ptr_d = ptr_q + PTR_W'(1);
      end
    end

    if (load) begin
      shift_d      = dataWord;
      word_sync_d  = 1'b1;
      frame_sync_d = frame_pend_q;
    end

    ser_data_d = (state_d == SHIFT) ? shift_d[WORD_BITS-1] : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      ptr_q        <= PTR_W'(FRAME_WORDS - 1);
      grp_q        <= GRP_W'(GROUPS - 1);
      shift_q      <= '0;
      prime_q      <= 1'b0;
      stop_q       <= 1'b0;
      frame_pend_q <= 1'b0;
      get_q        <= 1'b0;
      ser_data_q   <= 1'b0;
      word_sync_q  <= 1'b0;
      frame_sync_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      grp_q        <= grp_d;
      shift_q      <= shift_d;
      prime_q      <= prime_d;
      stop_q       <= stop_d;
      frame_pend_q <= frame_pend_d;
      get_q        <= get_d;
      ser_data_q   <= ser_data_d;
      word_sync_q  <= word_sync_d;
      frame_sync_q <= frame_sync_d;
    end
  end

  assign bufGetWord   = get_q;
  assign bufRdPointer = ptr_q;
  assign cntGrp       = grp_q;
  assign serData      = ser_data_q;
  assign wordSync     = word_sync_q;
  assign frameSync    = frame_sync_q;

endmodule

// File: doc/m4_frame_sequencer.md
Name: m4_frame_sequencer

Overview:
- Upstream timing master for the M4 word filler.
- Generates the per-word fetch strobe, buffer read pointer and frame-group counter.
- Captures the returned 12-bit word and shifts it out MSB-first as the serial telemetry stream, with bit clock and sync markers.
- One instance per M4 channel, placed between the global clock and the line driver.

Parameters:
- BIT_DIV, 4, clk cycles per serial bit; minimum 4.
- WORD_BITS, 12, bits per word; equals the filler dataWord width.
- FRAME_WORDS, 512, words per frame; pointer wraps at FRAME_WORDS-1.
- GROUPS, 32, frames per group cycle; cntGrp wraps at GROUPS-1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- en  in  1  run enable, sampled only at fetch points
- dataWord  in  12  word returned by the filler; valid from the edge after bufGetWord
- bufGetWord  out  1  one-cycle fetch strobe
- bufRdPointer  out  9  word index being fetched
- cntGrp  out  5  frame-group counter
- serData  out  1  serial data, MSB first
- serClk  out  1  bit clock; high for the first BIT_DIV/2 cycles of each bit
- wordSync  out  1  one-cycle pulse on the first cycle of every word
- frameSync  out  1  one-cycle pulse on the first cycle of word 0

Behaviour:
- Single clock domain. Reset is synchronous and active-low: when reset=0 at a rising clk edge, all registers take their reset values.
- Reset values:
  - bufGetWord=0, serData=0, serClk=0, wordSync=0, frameSync=0.
  - bufRdPointer=FRAME_WORDS-1, cntGrp=GROUPS-1, so the first fetch wraps both to 0.
  - state=IDLE, divCnt=0, bitCnt=0, shift register=0.
- Fetch rule, applied on every fetch:
  - bufGetWord is registered and high for exactly one cycle.
  - On the same edge, bufRdPointer <= (ptr==FRAME_WORDS-1) ? 0 : ptr+1.
  - When the pointer wraps, cntGrp <= (cntGrp==GROUPS-1) ? 0 : cntGrp+1. The cntGrp change is visible together with pointer 0.
- States:
  - IDLE: serData=0, serClk=0. If en=1, issue a fetch and go to PRIME.
  - PRIME: wait 2 cycles, then load the shift register from dataWord and go to SHIFT with divCnt=0, bitCnt=0. The first word is therefore output 3 cycles after the fetch.
  - SHIFT:
    - divCnt counts 0..BIT_DIV-1. At BIT_DIV-1, bitCnt advances (0..WORD_BITS-1) and the shift register shifts left.
    - serData = shift register MSB. serClk = (divCnt < BIT_DIV/2).
    - At bitCnt==WORD_BITS-1 and divCnt==BIT_DIV-3: if en=1, issue a fetch; otherwise record stop.
    - At bitCnt==WORD_BITS-1 and divCnt==BIT_DIV-1: if a fetch was issued, load dataWord, reset both counters and stay in SHIFT (back-to-back words, no gap). If stop was recorded, go to IDLE.
- Word period is WORD_BITS*BIT_DIV cycles; serData carries no idle bits between words.
- wordSync is high on the first cycle of a word's bit 0. frameSync is additionally high on that cycle when the word loaded was fetched with pointer 0.
- en deasserted mid-word: the current word completes, then the block idles.
- en reasserted: resumes with the next pointer, so no word is repeated or skipped. The pointer and cntGrp are held while idle.
- dataWord is sampled only on load edges and is ignored at all other times.
- Reset asserted mid-word: the word is abandoned and all outputs return to reset values on the next edge.

Decomposition:
- Shared package m4_pkg holds:
  - M4_WORD_BITS=12, M4_FRAME_WORDS=512, M4_GROUPS=32.
  - the state enum {IDLE, PRIME, SHIFT}, shared with the filler and line-driver benches.
- One sub-module: m4_bit_timer, containing divCnt/bitCnt, serClk and the fetch-point and load-point decode.
- Pointer/group logic and the shift register stay in the top module.

Test Plan:
- Reset then en=1, BIT_DIV=4: bufGetWord at cycle 1 with pointer 0 and cntGrp 0; dataWord=12'hA5C returned; serData outputs 1,0,1,0,0,1,0,1,1,1,0,0 at 4 cycles per bit; wordSync and frameSync fire at load.
- Continuous run: fetch strobes exactly 48 cycles apart; word n+1's first bit follows word n's last bit with no gap; pointer sequence 0,1,2,…
- Pointer wrap: after 512 fetches, pointer returns to 0, cntGrp goes 0→1 on that same edge, and frameSync pulses; after 32 frames, cntGrp goes 31→0.
- en dropped at bit 5 of word 7: word 7 completes, no fetch for word 8, IDLE with serData=0; en reasserted: the next fetch uses pointer 8.
- Reset mid-word (bit 6): the next edge shows pointer=511, cntGrp=31, serData=0, state IDLE.
- dataWord toggled every cycle: only the value present on each load edge appears on serData.
